fft_bit_reverse_pairer: RTL

- Upstream feeder for the first radix-2 butterfly stage of the FFT datapath.
- Accepts one frame of `size` complex samples serially, in natural order, over a val/rdy stream.
- Buffers the frame, then emits `size/2` transactions. Each transaction carries one (a, b) operand pair in bit-reversed order, which is exactly the first-stage DIT pairing.
- Also drives the stage-1 twiddle, which is constant w = 1 + 0j.

---
 rtl/fft_bit_reverse_pairer_pkg.sv | 25 ++
 rtl/fft_bit_reverse_pairer_complex_regfile.sv | 28 ++
 rtl/fft_bit_reverse_pairer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fft_bit_reverse_pairer_pkg.sv
// Shared FFT definitions: pairer FSM states, index bit reversal and the
// fixed-point unity constant used to build twiddle factors.
package fft_bit_reverse_pairer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } pair_state_t;

  // Reverse the low `logs` bits of idx; bits above `logs` come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int unsigned logs);
    logic [31:0] r;
    r = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < logs) r[5'(logs - 1 - k)] = idx[5'(k)];
    end
    return r;
  endfunction

  // Fixed-point 1.0 for a word with `frac` fractional bits.
  function automatic logic [63:0] fixed_one(input int frac);
    return 64'(1) << frac;
  endfunction

endpackage

// File: rtl/fft_bit_reverse_pairer_complex_regfile.sv
// Frame buffer of complex samples {r, c}: one synchronous write port and
// two independent combinational read ports (operand a and operand b).
module fft_bit_reverse_pairer_complex_regfile #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  logic [2*N-1:0] wdata_i,
  input  logic [AW-1:0]  raddr_a_i,
  input  logic [AW-1:0]  raddr_b_i,
  output logic [2*N-1:0] rdata_a_o,
  output logic [2*N-1:0] rdata_b_o
);

  logic [2*N-1:0] mem_q [DEPTH];

  // Sample storage; deliberately not reset, every slot is rewritten per frame.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/fft_bit_reverse_pairer.sv
// Feeder for the first radix-2 DIT butterfly stage: buffers one frame in
// natural order, then presents it as bit-reversed (a, b) pairs with w = 1.
//
//   state | meaning
//   FILL  | accepting samples into the buffer, recv_rdy high
//   DRAIN | presenting pairs, send_val high, inputs ignored
module fft_bit_reverse_pairer
  import fft_bit_reverse_pairer_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int size = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_r,
  input  logic [n-1:0] recv_c,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] ar,
  output logic [n-1:0] ac,
  output logic [n-1:0] br,
  output logic [n-1:0] bc,
  output logic [n-1:0] wr,
  output logic [n-1:0] wc
);

  localparam int LOGS = $clog2(size);
  // Pair counter needs LOGS-1 bits, but never narrower than one bit.
  localparam int KW   = (LOGS > 1) ? LOGS - 1 : 1;

  pair_state_t     state_q, state_d;
  logic [LOGS-1:0] wptr_q, wptr_d;
  logic [KW-1:0]   kptr_q, kptr_d;

  logic            recv_fire;
  logic            send_fire;
  logic [LOGS-1:0] idx_a, idx_b;
  logic [LOGS-1:0] raddr_a, raddr_b;
  logic [2*n-1:0]  rdata_a, rdata_b;

  assign recv_fire = recv_val & recv_rdy;
  assign send_fire = send_val & send_rdy;

  // Pair k covers natural indices 2k and 2k+1 before reversal.
  assign idx_a   = LOGS'({kptr_q, 1'b0});
  assign idx_b   = idx_a | LOGS'(1);
  assign raddr_a = LOGS'(bit_reverse(32'(idx_a), LOGS));
  assign raddr_b = LOGS'(bit_reverse(32'(idx_b), LOGS));

  fft_bit_reverse_pairer_complex_regfile #(
    .N    (n),
    .DEPTH(size),
    .AW   (LOGS)
  ) u_regfile (
    .clk      (clk),
    .we_i     (recv_fire),
    .waddr_i  (wptr_q),
    .wdata_i  ({recv_r, recv_c}),
    .raddr_a_i(raddr_a),
    .raddr_b_i(raddr_b),
    .rdata_a_o(rdata_a),
    .rdata_b_o(rdata_b)
  );

  // State and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      wptr_q  <= '0;
      kptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      kptr_q  <= kptr_d;
    end
  end

  // Next-state and pointer advance; handshakes only move their own pointer.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    kptr_d  = kptr_q;
    unique case (state_q)
      FILL: begin
        if (recv_fire) begin
          if (wptr_q == LOGS'(size - 1)) begin
            wptr_d  = '0;
            state_d = DRAIN;
          end else begin
            wptr_d = wptr_q + LOGS'(1);
          end
        end
      end
      DRAIN: begin
        if (send_fire) begin
          if (kptr_q == KW'(size / 2 - 1)) begin
            kptr_d  = '0;
            state_d = FILL;
          end else begin
            kptr_d = kptr_q + KW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Stream flags and operand outputs; operands are zeroed outside DRAIN.
  always_comb begin
    recv_rdy = (state_q == FILL);
    send_val = (state_q == DRAIN);
    ar = '0;
    ac = '0;
    br = '0;
    bc = '0;
    if (send_val) begin
      ar = rdata_a[2*n-1:n];
      ac = rdata_a[n-1:0];
      br = rdata_b[2*n-1:n];
      bc = rdata_b[n-1:0];
    end
  end

  assign wr = n'(fixed_one(d));
  assign wc = '0;

endmodule
